// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the data-RAM arbiter and the RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [31:0]       cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              cpu_err;

   logic              dma_req;
   logic              dma_we;
   logic [31:0]       dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_ack;
   logic              dma_err;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_err,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_rdata, dma_ack, dma_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_err,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_rdata, dma_ack, dma_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between the
// CPU load/store port and the DMA port; pipelined issue, one access per cycle.
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 32
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   logic ack_cpu_q, ack_cpu_d;
   logic err_cpu_q, err_cpu_d;
   logic rd_cpu_q,  rd_cpu_d;
   logic ack_dma_q, ack_dma_d;
   logic err_dma_q, err_dma_d;
   logic rd_dma_q,  rd_dma_d;
   logic last_dma_q, last_dma_d;

   logic              cpu_elig, dma_elig;
   logic              gnt_cpu, gnt_dma;
   logic              cpu_ok, dma_ok, sel_ok;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   function automatic logic addr_ok(input logic [31:0] addr);
      return (addr[1:0] == 2'b00) && (addr[31:ADDR_W+2] == '0);
   endfunction

   always_comb begin
      // A port in its ack/err cycle still holds req; that is the old request.
      cpu_elig = bus.cpu_req & ~(ack_cpu_q | err_cpu_q);
      dma_elig = bus.dma_req & ~(ack_dma_q | err_dma_q);

      gnt_cpu = cpu_elig & (~dma_elig | last_dma_q);
      gnt_dma = dma_elig & ~gnt_cpu;

      cpu_ok = addr_ok(bus.cpu_addr);
      dma_ok = addr_ok(bus.dma_addr);
      sel_ok = (gnt_cpu & cpu_ok) | (gnt_dma & dma_ok);

      sel_we    = gnt_dma ? bus.dma_we                 : bus.cpu_we;
      sel_addr  = gnt_dma ? bus.dma_addr[ADDR_W+1:2]   : bus.cpu_addr[ADDR_W+1:2];
      sel_wdata = gnt_dma ? bus.dma_wdata              : bus.cpu_wdata;

      ack_cpu_d = gnt_cpu & cpu_ok;
      err_cpu_d = gnt_cpu & ~cpu_ok;
      rd_cpu_d  = gnt_cpu & cpu_ok & ~bus.cpu_we;
      ack_dma_d = gnt_dma & dma_ok;
      err_dma_d = gnt_dma & ~dma_ok;
      rd_dma_d  = gnt_dma & dma_ok & ~bus.dma_we;

      // Invalid wins still count as service for fairness.
      last_dma_d = (gnt_cpu | gnt_dma) ? gnt_dma : last_dma_q;
   end

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (reset && sel_ok) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = sel_we;
         bus.mem_addr  = sel_addr;
         bus.mem_wdata = sel_wdata;
      end

      bus.cpu_ack   = ack_cpu_q;
      bus.cpu_err   = err_cpu_q;
      bus.cpu_rdata = rd_cpu_q ? bus.mem_rdata : '0;
      bus.dma_ack   = ack_dma_q;
      bus.dma_err   = err_dma_q;
      bus.dma_rdata = rd_dma_q ? bus.mem_rdata : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_cpu_q  <= 1'b0;
         err_cpu_q  <= 1'b0;
         rd_cpu_q   <= 1'b0;
         ack_dma_q  <= 1'b0;
         err_dma_q  <= 1'b0;
         rd_dma_q   <= 1'b0;
         last_dma_q <= 1'b1;
      end else begin
         ack_cpu_q  <= ack_cpu_d;
         err_cpu_q  <= err_cpu_d;
         rd_cpu_q   <= rd_cpu_d;
         ack_dma_q  <= ack_dma_d;
         err_dma_q  <= err_dma_d;
         rd_dma_q   <= rd_dma_d;
         last_dma_q <= last_dma_d;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port synchronous data RAM between the CPU load/store port and a DMA/loader port.
- Sits between the core's data-memory interface and the data RAM inside top. The DMA port preloads and inspects RAM while the core runs.
- Round-robin fairness, word-aligned accesses only, one-cycle RAM read latency. Issue is pipelined so sustained throughput is one access per cycle.

Parameters:
- ADDR_W, 6, RAM word-address width (RAM depth = 2**ADDR_W words)
- DATA_W, 32, data width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- cpu_req  in  1  CPU request, held until cpu_ack/cpu_err
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack & ~cpu_we
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle error pulse (misaligned/out of range)
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack, dma_err  same as cpu_* for the DMA port
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en & ~mem_we

Behaviour:
- Reset state: all outputs 0, owner register empty, last_served = DMA (so the CPU wins the first tie).
- Reset assertion is asynchronous. It drops any in-flight access with no ack/err, and mem_en is forced 0 while reset=0.
- Eligible requester: req=1 and not currently in its response cycle. A requester being acked this cycle is excluded even though its req is still high.
- Issue (combinational, same cycle):
  - One eligible requester: it wins.
  - Both eligible: the one not in last_served wins.
  - Winner drives mem_en=1, mem_we=we, mem_addr=addr[ADDR_W+1:2], mem_wdata=wdata.
- Validity check: addr[1:0]!=0, or addr[31:ADDR_W+2]!=0, is invalid.
  - An invalid winner gets mem_en=0 (no RAM access) and an err pulse next cycle instead of ack.
  - last_served still updates on an invalid win.
- Response cycle (issue cycle + 1):
  - Registered ack (or err) pulses for exactly one cycle to the winner.
  - rdata = mem_rdata on a read ack; otherwise the port's rdata = 0.
  - last_served <= winner at the issue edge.
- Pipelining: the other requester may issue during a response cycle, giving back-to-back alternating service.
- The same requester cannot issue in two consecutive cycles, because it must deassert or re-present req after ack. Its earliest re-issue is the cycle after its ack.
- Requester rule: req/we/addr/wdata are held stable from req rise until ack/err. Deasserting req before ack is illegal (behaviour undefined); it is not checked.
- Write-then-read to the same address by different ports, issued in consecutive cycles, returns the new data (the RAM is write-before-read sequential).
- No starvation: with both ports continuously requesting, grants strictly alternate.
- Latency: ack/err exactly 1 cycle after issue; a grant is delayed by at most 1 cycle of contention.

Test Plan:
- Reset, DMA writes 32'd7 to addr 84 -> mem_en=1, mem_addr=21 in the issue cycle, dma_ack next cycle. Then CPU reads addr 84 -> cpu_ack with cpu_rdata=32'd7.
- CPU and DMA both request a read in the same cycle right after reset -> CPU issues first, DMA issues in the next cycle. The acks land in consecutive cycles, CPU then DMA.
- Both ports hold req continuously for 8 accesses -> grants alternate C,D,C,D…; each port receives 4 acks within the window; no two consecutive grants go to the same port.
- CPU read at addr 86 (misaligned) and DMA write at addr 256 (out of range, ADDR_W=6) -> mem_en stays 0 for both, cpu_err and dma_err each pulse once, and RAM contents are unchanged.
- Drive reset=0 in the cycle after a DMA write issues -> dma_ack is never asserted, all outputs are 0 asynchronously, and after release the CPU wins the first tie.
- DMA writes 32'hDEADBEEF to addr 0 while the CPU reads addr 0 in the following cycle -> cpu_rdata=32'hDEADBEEF.
